parity_accum: RTL
=================

PARITY_ACCUM -- requirements
Module: parity_accum

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 1..64.
REQ-002 Parameter FRAME_LEN, default 4: words per frame, legal range 1..256.
REQ-003 Parameter ODD, default 0: 0 selects even parity, 1 selects odd parity (result inverted).
REQ-004 Parameter CW = max(1, clog2(FRAME_LEN)), derived: width of the count output.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 valid  input  1  data word is accepted on a clk edge where valid=1.
REQ-008 data  input  WIDTH  data word.
REQ-009 chk  input  1  expected frame parity; sampled only with the last word of a frame.
REQ-010 clear  input  1  clears err_sticky.
REQ-011 y  output  1  registered parity of the most recently accepted word.
REQ-012 frame_par  output  1  registered parity of the most recently completed frame.
REQ-013 done  output  1  one-cycle pulse: frame completed.
REQ-014 err  output  1  one-cycle pulse: frame parity != chk.
REQ-015 err_sticky  output  1  latched error flag.
REQ-016 count  output  CW  index of the next word within the current frame.

Function
REQ-017 Word parity wp SHALL be XOR-reduce(data) XOR ODD.
REQ-018 On each accepted word, y SHALL take wp one cycle later (latency 1); y holds while valid=0.
REQ-019 Internal accumulator acc (1 bit) SHALL hold the XOR of all raw data bits accepted so far in the current frame, without ODD applied.
REQ-020 Two states, derived from count: IDLE (count==0) and ACTIVE (count>0); no other state register.
REQ-021 Accepted word with count<FRAME_LEN-1: acc <= acc XOR XOR-reduce(data); count <= count+1; done=0, err=0 next cycle.
REQ-022 Accepted word with count==FRAME_LEN-1 (last word): frame_par <= acc XOR XOR-reduce(data) XOR ODD; done <= 1; err <= (new frame_par != chk); acc <= 0; count <= 0 (wrap).
REQ-023 FRAME_LEN=1: every accepted word is a last word; done pulses on every accepted cycle; frame_par equals y.
REQ-024 valid=0: acc, count, y, and frame_par hold; done=0, err=0 next cycle.
REQ-025 Back-to-back frames with valid held high SHALL have no bubble; done pulses once per FRAME_LEN words.
REQ-026 err_sticky <= 1 on any cycle in which err is set; cleared by clear=1 otherwise.
REQ-027 Simultaneous clear=1 and error detection: set wins, err_sticky=1.
REQ-028 frame_par and err SHALL change only on a last-word acceptance.
REQ-029 chk is ignored on non-last words.

Reset
REQ-030 reset=1 at a clk edge SHALL force y=0, frame_par=0, done=0, err=0, err_sticky=0, count=0, acc=0.
REQ-031 reset SHALL take priority over valid and clear in the same cycle.
REQ-032 Reset mid-frame SHALL discard the partial frame; the first accepted word after reset is word 0 of a new frame.

Verification (WIDTH=4, FRAME_LEN=4, ODD=0 unless noted)
REQ-033 Words 0001, 0011, 0111, 1111 on consecutive cycles with chk=0 on the last word: y sequence 1,0,1,0; done pulses once after the 4th word; frame_par=0; err=0; count 0,1,2,3,0.
REQ-034 Same words with chk=1: err pulses 1 cycle together with done; err_sticky stays 1; clear=1 for one cycle -> err_sticky=0.
REQ-035 ODD=1, words 0000 x4 with chk=1: each y=1; frame_par=1; err=0.
REQ-036 Words 0001, gap (valid=0 for 3 cycles), 0001, 0000, 0000: count holds at 1 during the gap; frame_par=0 after the 4th word; done does not pulse during the gap.
REQ-037 After 2 words of a frame, assert reset for 1 cycle: all outputs 0; then 4 words 1000,0000,0000,0000 -> frame_par=1, done pulses after the 4th word only.
REQ-038 FRAME_LEN=1, continuous valid with words 1010, 1110, chk=0: done=1 on both cycles; err on the 2nd only; err_sticky=1 even with clear=1 in that cycle.

Source files
------------

// File: rtl/parity_accum.sv
// rtl/parity_accum.sv - streaming word/frame parity accumulator with frame check
// Frame position lives only in count_q; IDLE/ACTIVE are decoded from it.
module parity_accum #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int ODD       = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic [WIDTH-1:0]       data,
    input  logic                   chk,
    input  logic                   clear,
    output logic                   y,
    output logic                   frame_par,
    output logic                   done,
    output logic                   err,
    output logic                   err_sticky,
    output logic [((FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1)-1:0] count
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic ODD_BIT = (ODD != 0);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_e;

    state_e        state;
    logic          word_xor;
    logic          last_word;
    logic          acc_base;
    logic          frame_sum;

    logic          y_q, y_d;
    logic          frame_par_q, frame_par_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          err_sticky_q, err_sticky_d;
    logic          acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        state = (count_q == '0) ? S_IDLE : S_ACTIVE;
    end

    assign word_xor  = ^data;
    assign last_word = (count_q == LAST_IDX);

    // A word landing in IDLE always opens a fresh frame, so it never folds in acc_q.
    assign acc_base  = (state == S_IDLE) ? 1'b0 : acc_q;
    assign frame_sum = acc_base ^ word_xor;

    always_comb begin
        y_d          = y_q;
        frame_par_d  = frame_par_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        acc_d        = acc_q;
        count_d      = count_q;
        err_sticky_d = err_sticky_q;

        if (valid) begin
            y_d = word_xor ^ ODD_BIT;
            if (last_word) begin
                frame_par_d = frame_sum ^ ODD_BIT;
                done_d      = 1'b1;
                err_d       = (frame_sum ^ ODD_BIT) != chk;
                acc_d       = 1'b0;
                count_d     = '0;
            end else begin
                acc_d   = frame_sum;
                count_d = count_q + CW'(1);
            end
        end

        // A fresh error outranks a same-cycle clear.
        if (err_d) begin
            err_sticky_d = 1'b1;
        end else if (clear) begin
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q          <= 1'b0;
            frame_par_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            acc_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            y_q          <= y_d;
            frame_par_q  <= frame_par_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
        end
    end

    assign y          = y_q;
    assign frame_par  = frame_par_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign count      = count_q;

endmodule
